note_display_ctrl: RTL

NOTE_DISPLAY_CTRL -- requirements
Module: note_display_ctrl

---
 rtl/note_display_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/note_display_ctrl.sv
// Note display controller: debounces detected notes into a committed note,
// then sequences display hold and per-channel colour fade on frame ticks.
//
// state | meaning
// IDLE  | nothing shown, note output 0
// SHOW  | committed note shown at full colour, counting inactive frames
// FADE  | colour dimmed by fade_lvl (1..7), one step per frame
module note_display_ctrl #(
  parameter int STABLE_CNT  = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        note_valid,
  input  logic [5:0]  note_in,
  input  logic        frame_tick,
  input  logic [23:0] color_in,
  output logic [5:0]  note,
  output logic [23:0] color,
  output logic        display_en
);

  localparam logic [3:0] CNT_MAX   = 4'(STABLE_CNT);
  localparam logic [3:0] CNT_PRE   = 4'(STABLE_CNT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    FADE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  note_q, note_d;
  logic [5:0]  cand_q, cand_d;
  logic [3:0]  cand_cnt_q, cand_cnt_d;
  logic [5:0]  pend_q, pend_d;
  logic        pend_flag_q, pend_flag_d;
  logic        activity_q, activity_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [2:0]  fade_lvl_q, fade_lvl_d;
  logic [23:0] color_q, color_d;
  logic        display_en_q, display_en_d;

  logic strobe_nz;
  logic cand_hit;
  logic accept;

  assign strobe_nz = note_valid && (note_in != 6'd0);
  assign cand_hit  = strobe_nz && (note_in == cand_q);
  // Only the STABLE_CNT-1 -> STABLE_CNT transition accepts; a saturated
  // counter keeps matching without re-arming the pending note.
  assign accept    = cand_hit && (cand_cnt_q == CNT_PRE);

  always_comb begin
    cand_d     = cand_q;
    cand_cnt_d = cand_cnt_q;
    if (strobe_nz) begin
      if (cand_hit) begin
        if (cand_cnt_q < CNT_MAX) cand_cnt_d = cand_cnt_q + 4'd1;
      end else begin
        cand_d     = note_in;
        cand_cnt_d = 4'd1;
      end
    end
  end

  // A set from a coincident strobe wins over the clear from the tick.
  always_comb begin
    pend_d      = accept ? cand_q : pend_q;
    pend_flag_d = pend_flag_q;
    activity_d  = activity_q;
    if (frame_tick) begin
      pend_flag_d = 1'b0;
      activity_d  = 1'b0;
    end
    if (accept) pend_flag_d = 1'b1;
    if (strobe_nz && (note_in == note_q)) activity_d = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    note_d     = note_q;
    hold_cnt_d = hold_cnt_q;
    fade_lvl_d = fade_lvl_q;
    if (frame_tick) begin
      if (pend_flag_q) begin
        note_d     = pend_q;
        state_d    = SHOW;
        fade_lvl_d = 3'd0;
        hold_cnt_d = 8'd0;
      end else begin
        unique case (state_q)
          SHOW: begin
            if (activity_q) begin
              hold_cnt_d = 8'd0;
            end else if (hold_cnt_q < HOLD_LAST) begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end else begin
              state_d    = FADE;
              fade_lvl_d = 3'd1;
            end
          end
          FADE: begin
            if (fade_lvl_q != 3'd7) begin
              fade_lvl_d = fade_lvl_q + 3'd1;
            end else begin
              state_d    = IDLE;
              note_d     = 6'd0;
              fade_lvl_d = 3'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Colour is blanked while idle so the display shows nothing between notes.
  always_comb begin
    color_d = 24'd0;
    if (state_q != IDLE) begin
      color_d = {color_in[23:16] >> fade_lvl_q,
                 color_in[15:8]  >> fade_lvl_q,
                 color_in[7:0]   >> fade_lvl_q};
    end
    display_en_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      note_q       <= 6'd0;
      cand_q       <= 6'd0;
      cand_cnt_q   <= 4'd0;
      pend_q       <= 6'd0;
      pend_flag_q  <= 1'b0;
      activity_q   <= 1'b0;
      hold_cnt_q   <= 8'd0;
      fade_lvl_q   <= 3'd0;
      color_q      <= 24'd0;
      display_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      note_q       <= note_d;
      cand_q       <= cand_d;
      cand_cnt_q   <= cand_cnt_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      activity_q   <= activity_d;
      hold_cnt_q   <= hold_cnt_d;
      fade_lvl_q   <= fade_lvl_d;
      color_q      <= color_d;
      display_en_q <= display_en_d;
    end
  end

  assign note       = note_q;
  assign color      = color_q;
  assign display_en = display_en_q;

endmodule
